// File: rtl/frame_reception_if.sv
// frame_reception_if: byte stream from the PHY side and parsed-frame outputs to the MAC client.
interface frame_reception_if;
    logic [7:0]  rx_in;
    logic        rx_dv;
    logic [47:0] dest_addr;
    logic [47:0] src_addr;
    logic [15:0] eth_type;
    logic [31:0] data_out;
    logic        rx_valid;
    logic        rx_err;
    logic        rx_busy;
    modport master (
        output rx_in, rx_dv,
        input  dest_addr, src_addr, eth_type, data_out, rx_valid, rx_err, rx_busy
    );
    modport slave (
        input  rx_in, rx_dv,
        output dest_addr, src_addr, eth_type, data_out, rx_valid, rx_err, rx_busy
    );
endinterface

// File: rtl/frame_reception.sv
// frame_reception: byte-wide Ethernet frame receiver (preamble/SFD hunt, header + payload parse).
// Define RX_ADDR_FILTER_EN to silently drop frames not addressed to LOCAL_MAC or broadcast.
module frame_reception #(
    parameter int          MIN_PREAMBLE = 2,
    parameter logic [7:0]  TRAILER_BYTE = 8'hFF,
    parameter logic [47:0] LOCAL_MAC    = 48'h0200_0000_0001
) (
    input logic clk,
    input logic rst_n,
    frame_reception_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_PRE, S_DEST, S_SRC, S_TYPE, S_PAY, S_TRL, S_DROP} state_t;
    localparam logic [2:0] MIN_P = 3'(MIN_PREAMBLE);
    state_t       state_q, state_d;
    logic [2:0]   cnt_q, cnt_d;
    logic [143:0] sh_q, sh_d;
    logic [47:0]  dest_q, dest_d, src_q, src_d;
    logic [15:0]  type_q, type_d;
    logic [31:0]  data_q, data_d;
    logic         valid_q, valid_d, err_q, err_d;
    logic         dv, in_frame, sfd_ok, trl_ok, addr_ok;
    logic [7:0]   b;
    assign dv       = bus.rx_dv;
    assign b        = bus.rx_in;
    assign sfd_ok   = b == 8'hD5 && cnt_q >= MIN_P;
    assign trl_ok   = b == TRAILER_BYTE;
    assign in_frame = state_q != S_IDLE && state_q != S_DROP;
`ifdef RX_ADDR_FILTER_EN
    assign addr_ok = sh_q[143:96] == LOCAL_MAC || &sh_q[143:96];
`else
    logic unused_mac;
    assign unused_mac = ^LOCAL_MAC;
    assign addr_ok    = 1'b1;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            dest_q  <= '0;
            src_q   <= '0;
            type_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            dest_q  <= dest_d;
            src_q   <= src_d;
            type_q  <= type_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = !dv ? S_IDLE : b == 8'h55 ? S_PRE : S_DROP;
            S_PRE:   state_d = !dv ? S_IDLE : b == 8'h55 ? S_PRE : sfd_ok ? S_DEST : S_DROP;
            S_DEST:  state_d = !dv ? S_IDLE : cnt_q == 3'd5 ? S_SRC : S_DEST;
            S_SRC:   state_d = !dv ? S_IDLE : cnt_q == 3'd5 ? S_TYPE : S_SRC;
            S_TYPE:  state_d = !dv ? S_IDLE : cnt_q == 3'd1 ? S_PAY : S_TYPE;
            S_PAY:   state_d = !dv ? S_IDLE : cnt_q == 3'd3 ? S_TRL : S_PAY;
            S_TRL:   state_d = !dv || trl_ok ? S_IDLE : S_DROP;
            S_DROP:  state_d = dv ? S_DROP : S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // the first 0x55 is consumed in IDLE, so the preamble count starts at 1
        cnt_d = state_d != state_q ? (state_d == S_PRE ? 3'd1 : 3'd0)
              : cnt_q == 3'd7 ? cnt_q : cnt_q + 3'd1;
    end
    always_comb begin
        sh_d    = in_frame && dv && state_q != S_PRE && state_q != S_TRL ? {sh_q[135:0], b} : sh_q;
        valid_d = state_q == S_TRL && dv && trl_ok && addr_ok;
        err_d   = in_frame && (!dv || state_d == S_DROP);
        dest_d  = valid_d ? sh_q[143:96] : dest_q;
        src_d   = valid_d ? sh_q[95:48]  : src_q;
        type_d  = valid_d ? sh_q[47:32]  : type_q;
        data_d  = valid_d ? sh_q[31:0]   : data_q;
    end
    assign bus.dest_addr = dest_q;
    assign bus.src_addr  = src_q;
    assign bus.eth_type  = type_q;
    assign bus.data_out  = data_q;
    assign bus.rx_valid  = valid_q;
    assign bus.rx_err    = err_q;
    assign bus.rx_busy   = state_q != S_IDLE;
endmodule
